// File: rtl/fe_capture_timestamper_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fe_capture_timestamper_if                                      |
// | Brief    : Signal bundle between the capture sequencer and its neighbours |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fe_capture_timestamper_if #(
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pCAPTURE_LEN_WIDTH    = 24
);
    logic                             I_arm;
    logic [pCAPTURE_LEN_WIDTH-1:0]    I_capture_len;
    logic                             I_event;
    logic [1:0]                       I_data_cmd;
    logic [15:0]                      I_max_short_timestamp;
    logic                             I_fifo_write_allowed;

    logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time;
    logic [1:0]                       O_fifo_command;
    logic                             O_fifo_wr;
    logic                             O_capturing;
    logic                             O_done;
    logic                             O_overflow;
    logic [pCAPTURE_LEN_WIDTH-1:0]    O_entries;

    modport master (
        output I_arm, I_capture_len, I_event, I_data_cmd,
               I_max_short_timestamp, I_fifo_write_allowed,
        input  O_fifo_time, O_fifo_command, O_fifo_wr, O_capturing,
               O_done, O_overflow, O_entries
    );

    modport slave (
        input  I_arm, I_capture_len, I_event, I_data_cmd,
               I_max_short_timestamp, I_fifo_write_allowed,
        output O_fifo_time, O_fifo_command, O_fifo_wr, O_capturing,
               O_done, O_overflow, O_entries
    );
endinterface
`default_nettype wire

// File: rtl/fe_capture_timestamper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fe_capture_timestamper                                         |
// | Brief    : Arm/capture/done sequencer producing timestamped FIFO entries  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module fe_capture_timestamper #(
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pCAPTURE_LEN_WIDTH    = 24
) (
    input  wire logic               fe_clk,
    input  wire logic               reset_i,
    fe_capture_timestamper_if.slave bus
);
    localparam logic [1:0] c_FE_FIFO_CMD_TIME = 2'b10;
    localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] c_TS_ONE =
        {{(pTIMESTAMP_FULL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pCAPTURE_LEN_WIDTH-1:0] c_LEN_ONE =
        {{(pCAPTURE_LEN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                           r_state;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] r_ts;
    logic                             r_pend_valid;
    logic [1:0]                       r_pend_cmd;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] r_pend_time;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] r_fifo_time;
    logic [1:0]                       r_fifo_cmd;
    logic                             r_fifo_wr;
    logic                             r_capturing;
    logic                             r_done;
    logic                             r_overflow;
    logic [pCAPTURE_LEN_WIDTH-1:0]    r_entries;

    logic [pTIMESTAMP_FULL_WIDTH-1:0] w_ts_next;
    logic                             w_ts_long;
    logic                             w_gap_entry;
    logic                             w_issue;
    logic [1:0]                       w_cmd;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] w_time;
    logic                             w_pend_load;
    logic                             w_pend_clr;
    logic [1:0]                       w_pend_cmd;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] w_pend_time;
    logic [pCAPTURE_LEN_WIDTH-1:0]    w_entries_inc;
    logic                             w_hit_len;
    logic                             w_stop;

    assign w_ts_next = bus.I_event ? c_TS_ONE :
                       ((&r_ts) ? r_ts : r_ts + c_TS_ONE);
    assign w_ts_long = 32'(r_ts) > 32'(bus.I_max_short_timestamp);

    // A long gap emits a TIME entry first and defers the event's own entry by one cycle.
    always_comb begin
        w_gap_entry = 1'b0;
        w_issue     = 1'b0;
        w_cmd       = r_pend_cmd;
        w_time      = r_pend_time;
        w_pend_load = 1'b0;
        w_pend_clr  = 1'b0;
        w_pend_cmd  = bus.I_data_cmd;
        w_pend_time = r_ts;
        if (bus.I_arm) begin
            if (r_state == S_ARMED && bus.I_event) begin
                w_issue = 1'b1;
                w_cmd   = bus.I_data_cmd;
                w_time  = '0;
            end else if (r_state == S_CAPTURE) begin
                if (bus.I_event && w_ts_long) begin
                    w_gap_entry = 1'b1;
                    w_issue     = 1'b1;
                    w_cmd       = c_FE_FIFO_CMD_TIME;
                    w_time      = r_ts;
                    w_pend_load = 1'b1;
                    w_pend_time = '0;
                end else if (r_pend_valid) begin
                    w_issue = 1'b1;
                    if (bus.I_event) begin
                        w_pend_load = 1'b1;
                    end else begin
                        w_pend_clr = 1'b1;
                    end
                end else if (bus.I_event) begin
                    w_issue = 1'b1;
                    w_cmd   = bus.I_data_cmd;
                    w_time  = r_ts;
                end
            end
        end
    end

    assign w_entries_inc = (&r_entries) ? r_entries : r_entries + c_LEN_ONE;
    assign w_hit_len     = (bus.I_capture_len != '0) && (w_entries_inc == bus.I_capture_len);
    assign w_stop        = w_issue && (w_hit_len || !bus.I_fifo_write_allowed);

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_ts         <= '0;
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= 2'b00;
            r_pend_time  <= '0;
            r_fifo_time  <= '0;
            r_fifo_cmd   <= 2'b00;
            r_fifo_wr    <= 1'b0;
            r_capturing  <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_entries    <= '0;
        end else begin
            r_fifo_wr <= w_issue;
            r_ts      <= w_ts_next;
            if (w_issue) begin
                r_fifo_cmd  <= w_cmd;
                r_fifo_time <= w_time;
                r_entries   <= w_entries_inc;
            end
            if (w_pend_load) begin
                r_pend_valid <= 1'b1;
                r_pend_cmd   <= w_pend_cmd;
                r_pend_time  <= w_pend_time;
            end else if (w_pend_clr) begin
                r_pend_valid <= 1'b0;
            end

            if (!bus.I_arm) begin
                r_state      <= S_IDLE;
                r_pend_valid <= 1'b0;
                r_capturing  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        r_state     <= S_ARMED;
                        r_done      <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_entries   <= '0;
                        r_ts        <= '0;
                        r_capturing <= 1'b0;
                    end
                    default: begin
                        if (w_stop) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_pend_valid <= 1'b0;
                            r_capturing  <= 1'b0;
                            if (!bus.I_fifo_write_allowed) begin
                                r_overflow <= 1'b1;
                            end
                        end else if (w_issue) begin
                            r_state     <= S_CAPTURE;
                            r_capturing <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.O_fifo_time    = r_fifo_time;
    assign bus.O_fifo_command = r_fifo_cmd;
    assign bus.O_fifo_wr      = r_fifo_wr;
    assign bus.O_capturing    = r_capturing;
    assign bus.O_done         = r_done;
    assign bus.O_overflow     = r_overflow;
    assign bus.O_entries      = r_entries;

`ifndef SYNTHESIS
    // One-deep pending storage is enough only if a gap entry never meets a full slot.
    a_pend_drained : assert property (@(posedge fe_clk) disable iff (reset_i)
        !(w_gap_entry && r_pend_valid));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fe_capture_timestamper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fe_capture_timestamper                                      |
// | Brief    : Directed and random checks against a queue-based model         |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fe_capture_timestamper;
    localparam logic [1:0] c_DATA = 2'b00;
    localparam logic [1:0] c_STAT = 2'b01;
    localparam logic [1:0] c_TIME = 2'b10;
    localparam int c_TS_MAX  = 65535;
    localparam int c_CNT_MAX = (1 << 24) - 1;

    localparam int P_IDLE    = 0;
    localparam int P_ARMED   = 1;
    localparam int P_CAPTURE = 2;
    localparam int P_DONE    = 3;

    logic fe_clk  = 1'b0;
    logic reset_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    fe_capture_timestamper_if #(.pTIMESTAMP_FULL_WIDTH(16), .pCAPTURE_LEN_WIDTH(24)) bus ();

    fe_capture_timestamper #(.pTIMESTAMP_FULL_WIDTH(16), .pCAPTURE_LEN_WIDTH(24)) u_dut (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 fe_clk = ~fe_clk;

    typedef struct {
        logic [1:0] cmd;
        int         t;
    } entry_t;

    entry_t     pend_q[$];
    int         m_phase;
    int         m_ts;
    int         m_count;
    bit         m_done;
    bit         m_ovf;
    bit         m_wr;
    logic [1:0] m_cmd;
    int         m_time;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        pend_q.delete();
        m_phase = P_IDLE;
        m_ts    = 0;
        m_count = 0;
        m_done  = 0;
        m_ovf   = 0;
        m_wr    = 0;
        m_cmd   = 2'b00;
        m_time  = 0;
    endfunction

    function automatic void model_step();
        int     gap = m_ts;
        bit     ev  = bus.I_event;
        entry_t out[$];
        m_wr = 0;
        m_ts = ev ? 1 : ((m_ts < c_TS_MAX) ? m_ts + 1 : c_TS_MAX);
        if (!bus.I_arm) begin
            m_phase = P_IDLE;
            pend_q.delete();
            return;
        end
        if (m_phase == P_IDLE || m_phase == P_DONE) begin
            m_phase = P_ARMED;
            m_done  = 0;
            m_ovf   = 0;
            m_count = 0;
            m_ts    = 0;
            return;
        end
        if (m_phase == P_ARMED) begin
            if (ev) out.push_back('{cmd: bus.I_data_cmd, t: 0});
        end else if (ev && gap > int'(bus.I_max_short_timestamp)) begin
            out.push_back('{cmd: c_TIME, t: gap});
            pend_q.push_back('{cmd: bus.I_data_cmd, t: 0});
        end else begin
            if (pend_q.size() > 0) out.push_back(pend_q.pop_front());
            if (ev) begin
                if (out.size() > 0) pend_q.push_back('{cmd: bus.I_data_cmd, t: gap});
                else                out.push_back('{cmd: bus.I_data_cmd, t: gap});
            end
        end
        if (out.size() > 0) begin
            m_wr   = 1;
            m_cmd  = out[0].cmd;
            m_time = out[0].t;
            if (m_count < c_CNT_MAX) m_count++;
            if (m_phase == P_ARMED) m_phase = P_CAPTURE;
            if ((bus.I_capture_len != 0 && m_count == int'(bus.I_capture_len)) ||
                !bus.I_fifo_write_allowed) begin
                m_done = 1;
                if (!bus.I_fifo_write_allowed) m_ovf = 1;
                m_phase = P_DONE;
                pend_q.delete();
            end
        end
    endfunction

    task automatic compare_all();
        check("wr", bus.O_fifo_wr, m_wr);
        if (m_wr) begin
            check("cmd", bus.O_fifo_command, m_cmd);
            check("time", bus.O_fifo_time, m_time);
        end
        check("capturing", bus.O_capturing, (m_phase == P_CAPTURE));
        check("done", bus.O_done, m_done);
        check("overflow", bus.O_overflow, m_ovf);
        check("entries", bus.O_entries, m_count);
    endtask

    task automatic tick();
        @(posedge fe_clk);
        if (reset_i) model_reset();
        else         model_step();
        #1;
        compare_all();
    endtask

    task automatic expect_entry(input string tag, input logic [1:0] cmd, input int t);
        check({tag, "_wr"}, bus.O_fifo_wr, 1);
        check({tag, "_cmd"}, bus.O_fifo_command, cmd);
        check({tag, "_time"}, bus.O_fifo_time, t);
    endtask

    task automatic rearm();
        bus.I_arm = 1'b0;
        tick();
        bus.I_arm = 1'b1;
        tick();
        tick();
    endtask

    int n_wr;
    int idle_left;

    initial begin
        bus.I_arm                 = 1'b0;
        bus.I_capture_len         = '0;
        bus.I_event               = 1'b0;
        bus.I_data_cmd            = c_DATA;
        bus.I_max_short_timestamp = 16'd7;
        bus.I_fifo_write_allowed  = 1'b1;
        model_reset();
        tick();
        tick();
        check("rst_wr", bus.O_fifo_wr, 0);
        check("rst_entries", bus.O_entries, 0);
        check("rst_time", bus.O_fifo_time, 0);
        reset_i = 1'b0;

        // Short deltas: events at relative cycles 0, 1, 4
        rearm();
        bus.I_event = 1'b1; bus.I_data_cmd = c_STAT;
        tick(); expect_entry("first", c_STAT, 0);
        check("first_capturing", bus.O_capturing, 1);
        bus.I_data_cmd = c_DATA;
        tick(); expect_entry("second", c_DATA, 1);
        bus.I_event = 1'b0;
        tick(); tick();
        bus.I_event = 1'b1;
        tick(); expect_entry("third", c_DATA, 3);
        bus.I_event = 1'b0;

        // Long gap of 20 cycles produces TIME then the deferred entry
        rearm();
        bus.I_event = 1'b1; tick();
        bus.I_event = 1'b0;
        repeat (19) tick();
        bus.I_event = 1'b1; bus.I_data_cmd = c_STAT;
        tick(); expect_entry("gap_time", c_TIME, 20);
        bus.I_data_cmd = c_DATA;
        tick(); expect_entry("gap_pend", c_STAT, 0);
        bus.I_event = 1'b0;
        tick(); expect_entry("gap_next", c_DATA, 1);
        tick(); check("gap_quiet", bus.O_fifo_wr, 0);

        // Capture length of 3 with four back-to-back events
        bus.I_capture_len = 24'd3;
        rearm();
        n_wr = 0;
        bus.I_event = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_wr += int'(bus.O_fifo_wr);
            if (i == 2) begin
                check("len_done", bus.O_done, 1);
                check("len_capturing", bus.O_capturing, 0);
                check("len_entries", bus.O_entries, 3);
            end
        end
        bus.I_event = 1'b0;
        check("len_strobes", n_wr, 3);

        // Overflow on the second entry
        bus.I_capture_len = '0;
        rearm();
        bus.I_event = 1'b1; tick();
        bus.I_fifo_write_allowed = 1'b0;
        tick();
        check("ovf_wr", bus.O_fifo_wr, 1);
        check("ovf_flag", bus.O_overflow, 1);
        check("ovf_done", bus.O_done, 1);
        check("ovf_entries", bus.O_entries, 2);
        bus.I_arm = 1'b0;
        n_wr = 0;
        repeat (3) begin
            tick();
            n_wr += int'(bus.O_fifo_wr);
        end
        check("ovf_no_more", n_wr, 0);
        check("ovf_hold", bus.O_overflow, 1);
        bus.I_fifo_write_allowed = 1'b1;
        bus.I_event = 1'b0;

        // Asynchronous reset while an entry is pending
        bus.I_arm = 1'b1;
        tick(); tick();
        bus.I_event = 1'b1; tick();
        bus.I_event = 1'b0;
        repeat (10) tick();
        bus.I_event = 1'b1; tick();
        expect_entry("pre_rst", c_TIME, 11);
        bus.I_event = 1'b0;
        reset_i = 1'b1;
        model_reset();
        #1;
        check("arst_wr", bus.O_fifo_wr, 0);
        check("arst_entries", bus.O_entries, 0);
        tick();
        check("rst_edge_wr", bus.O_fifo_wr, 0);
        check("rst_edge_cap", bus.O_capturing, 0);
        reset_i = 1'b0;
        tick(); tick();
        check("rst_no_stale", bus.O_fifo_wr, 0);

        // Saturated timestamp after a very long gap, then re-arm from DONE
        bus.I_capture_len = 24'd3;
        bus.I_event = 1'b1; tick();
        bus.I_event = 1'b0;
        repeat (70000) tick();
        bus.I_event = 1'b1; bus.I_data_cmd = c_STAT;
        tick(); expect_entry("sat_time", c_TIME, 16'hFFFF);
        bus.I_event = 1'b0;
        bus.I_fifo_write_allowed = 1'b0;
        tick(); expect_entry("sat_pend", c_STAT, 0);
        check("sat_done", bus.O_done, 1);
        check("sat_ovf", bus.O_overflow, 1);
        bus.I_fifo_write_allowed = 1'b1;
        tick();
        check("rearm_entries", bus.O_entries, 0);
        check("rearm_done", bus.O_done, 0);
        check("rearm_ovf", bus.O_overflow, 0);

        // Random traffic
        bus.I_capture_len = '0;
        idle_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) bus.I_arm = ~bus.I_arm;
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.I_capture_len = 24'd0;
                    1:       bus.I_capture_len = 24'd4;
                    2:       bus.I_capture_len = 24'd9;
                    default: bus.I_capture_len = 24'd30;
                endcase
            end
            if ($urandom_range(0, 149) == 0)
                bus.I_max_short_timestamp = 16'($urandom_range(1, 12));
            if (idle_left > 0) begin
                idle_left--;
                bus.I_event = 1'b0;
            end else begin
                if ($urandom_range(0, 99) == 0) idle_left = $urandom_range(20, 60);
                bus.I_event = ($urandom_range(0, 99) < 35);
            end
            bus.I_data_cmd           = $urandom_range(0, 1) != 0 ? c_STAT : c_DATA;
            bus.I_fifo_write_allowed = ($urandom_range(0, 99) < 98);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
